// File: rtl/morse_player.sv
// Plays one letter A-Z as Morse keying in units of UNIT_TICKS tick pulses; signal/busy follow start by one cycle.
// No backpressure: start is only taken in IDLE and is dropped otherwise; done pulses for one cycle on return to IDLE.
module morse_player #(
    parameter int UNIT_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [4:0] letter,
    output logic       signal,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2,
        LGAP = 2'd3
    } state_t;

    localparam logic [9:0] T_UNIT  = 10'(UNIT_TICKS);
    localparam logic [9:0] T_TRIPLE = 10'(3 * UNIT_TICKS);

    // Entry format {len[2:0], pat[3:0]}; first element is pat[len-1], 1 = dash.
    function automatic logic [6:0] rom(input logic [4:0] l);
        case (l)
            5'd0:    rom = {3'd2, 4'b0001};
            5'd1:    rom = {3'd4, 4'b1000};
            5'd2:    rom = {3'd4, 4'b1010};
            5'd3:    rom = {3'd3, 4'b0100};
            5'd4:    rom = {3'd1, 4'b0000};
            5'd5:    rom = {3'd4, 4'b0010};
            5'd6:    rom = {3'd3, 4'b0110};
            5'd7:    rom = {3'd4, 4'b0000};
            5'd8:    rom = {3'd2, 4'b0000};
            5'd9:    rom = {3'd4, 4'b0111};
            5'd10:   rom = {3'd3, 4'b0101};
            5'd11:   rom = {3'd4, 4'b0100};
            5'd12:   rom = {3'd2, 4'b0011};
            5'd13:   rom = {3'd2, 4'b0010};
            5'd14:   rom = {3'd3, 4'b0111};
            5'd15:   rom = {3'd4, 4'b0110};
            5'd16:   rom = {3'd4, 4'b1101};
            5'd17:   rom = {3'd3, 4'b0010};
            5'd18:   rom = {3'd3, 4'b0000};
            5'd19:   rom = {3'd1, 4'b0001};
            5'd20:   rom = {3'd3, 4'b0001};
            5'd21:   rom = {3'd4, 4'b0001};
            5'd22:   rom = {3'd3, 4'b0011};
            5'd23:   rom = {3'd4, 4'b1001};
            5'd24:   rom = {3'd4, 4'b1011};
            5'd25:   rom = {3'd4, 4'b1100};
            default: rom = 7'd0;
        endcase
    endfunction

    state_t     state;
    logic [9:0] cnt;
    logic [3:0] pat;
    logic [1:0] idx;

    logic [6:0] ent;
    logic [2:0] first_idx;
    logic [9:0] target;
    logic       phase_end;

    always_comb begin
        ent       = rom(letter);
        first_idx = ent[6:4] - 3'd1;
        target    = T_UNIT;
        case (state)
            MARK:    target = pat[idx] ? T_TRIPLE : T_UNIT;
            GAP:     target = T_UNIT;
            LGAP:    target = T_TRIPLE;
            default: target = T_UNIT;
        endcase
        phase_end = tick && (cnt == target - 10'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 10'd0;
            pat    <= 4'd0;
            idx    <= 2'd0;
            signal <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 10'd0;
                    if (start && letter < 5'd26) begin
                        state  <= MARK;
                        pat    <= ent[3:0];
                        idx    <= first_idx[1:0];
                        signal <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                MARK: begin
                    if (phase_end) begin
                        cnt    <= 10'd0;
                        signal <= 1'b0;
                        state  <= (idx != 2'd0) ? GAP : LGAP;
                    end else if (tick) begin
                        cnt <= cnt + 10'd1;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        cnt    <= 10'd0;
                        idx    <= idx - 2'd1;
                        signal <= 1'b1;
                        state  <= MARK;
                    end else if (tick) begin
                        cnt <= cnt + 10'd1;
                    end
                end
                LGAP: begin
                    if (phase_end) begin
                        cnt   <= 10'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (tick) begin
                        cnt <= cnt + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_player.sv
// Directed bench for morse_player: one instance at UNIT_TICKS=2, one at UNIT_TICKS=1.
module tb_morse_player;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_a = 1'b0, start_a = 1'b0;
    logic [4:0] letter_a = 5'd0;
    logic       tick_b = 1'b0, start_b = 1'b0;
    logic [4:0] letter_b = 5'd0;
    logic       signal_a, busy_a, done_a;
    logic       signal_b, busy_b, done_b;

    int errors = 0;
    int checks = 0;

    logic [63:0] s_tr, b_tr, d_tr;

    always #5 clk = ~clk;

    morse_player #(.UNIT_TICKS(2)) dut_u2 (
        .clk(clk), .reset(reset), .tick(tick_a), .start(start_a), .letter(letter_a),
        .signal(signal_a), .busy(busy_a), .done(done_a)
    );

    morse_player #(.UNIT_TICKS(1)) dut_u1 (
        .clk(clk), .reset(reset), .tick(tick_b), .start(start_b), .letter(letter_b),
        .signal(signal_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit (c-1) represents cycle c, the cycle after edge c-1; start is sampled at edge 0.
    function automatic logic [63:0] cyc(input int first, input int last);
        logic [63:0] m = '0;
        for (int c = first; c <= last; c++) m[c-1] = 1'b1;
        return m;
    endfunction

    // sel=0 drives the UNIT_TICKS=2 instance, sel=1 the UNIT_TICKS=1 one.
    // slow: tick only on edges i%3==2. intr_at >= 0 issues a second start there.
    task automatic play(input bit sel, input logic [4:0] ltr, input int n, input bit slow,
                        input int intr_at, input logic [4:0] intr_ltr,
                        output logic [63:0] s, output logic [63:0] b, output logic [63:0] d);
        s = '0; b = '0; d = '0;
        for (int i = 0; i < n; i++) begin
            logic st, tk;
            logic [4:0] lt;
            st = (i == 0) || (i == intr_at);
            tk = slow ? (i % 3 == 2) : 1'b1;
            lt = (i == 0) ? ltr : ((i == intr_at) ? intr_ltr : 5'd31);
            if (sel) begin
                start_b = st; tick_b = tk; letter_b = lt;
            end else begin
                start_a = st; tick_a = tk; letter_a = lt;
            end
            @(posedge clk); #1;
            s[i] = sel ? signal_b : signal_a;
            b[i] = sel ? busy_b   : busy_a;
            d[i] = sel ? done_b   : done_a;
        end
        start_a = 1'b0; start_b = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_signal", {62'd0, signal_a, signal_b}, 64'd0);
        chk("rst_busy",   {62'd0, busy_a, busy_b},     64'd0);
        chk("rst_done",   {62'd0, done_a, done_b},     64'd0);
        reset = 1'b0;

        play(1'b0, 5'd4, 12, 1'b0, -1, 5'd0, s_tr, b_tr, d_tr);
        chk("E_signal", s_tr, cyc(1, 2));
        chk("E_busy",   b_tr, cyc(1, 8));
        chk("E_done",   d_tr, cyc(9, 9));

        play(1'b0, 5'd0, 20, 1'b0, -1, 5'd0, s_tr, b_tr, d_tr);
        chk("A_signal", s_tr, cyc(1, 2) | cyc(5, 10));
        chk("A_busy",   b_tr, cyc(1, 16));
        chk("A_done",   d_tr, cyc(17, 17));

        play(1'b1, 5'd16, 52, 1'b1, -1, 5'd0, s_tr, b_tr, d_tr);
        chk("Q_signal", s_tr, cyc(1, 8) | cyc(12, 20) | cyc(24, 26) | cyc(30, 38));
        chk("Q_busy",   b_tr, cyc(1, 47));
        chk("Q_done",   d_tr, cyc(48, 48));

        play(1'b0, 5'd26, 10, 1'b0, -1, 5'd0, s_tr, b_tr, d_tr);
        chk("bad_signal", s_tr, 64'd0);
        chk("bad_busy",   b_tr, 64'd0);
        chk("bad_done",   d_tr, 64'd0);

        play(1'b0, 5'd19, 16, 1'b0, -1, 5'd0, s_tr, b_tr, d_tr);
        chk("T_signal", s_tr, cyc(1, 6));
        chk("T_busy",   b_tr, cyc(1, 12));
        chk("T_done",   d_tr, cyc(13, 13));

        play(1'b0, 5'd19, 16, 1'b0, 3, 5'd7, s_tr, b_tr, d_tr);
        chk("Tint_signal", s_tr, cyc(1, 6));
        chk("Tint_busy",   b_tr, cyc(1, 12));
        chk("Tint_done",   d_tr, cyc(13, 13));

        play(1'b0, 5'd14, 3, 1'b0, -1, 5'd0, s_tr, b_tr, d_tr);
        chk("O_mid_signal", s_tr, cyc(1, 3));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("Orst_signal", {63'd0, signal_a}, 64'd0);
        chk("Orst_busy",   {63'd0, busy_a},   64'd0);
        chk("Orst_done",   {63'd0, done_a},   64'd0);

        play(1'b0, 5'd4, 12, 1'b0, -1, 5'd0, s_tr, b_tr, d_tr);
        chk("E2_signal", s_tr, cyc(1, 2));
        chk("E2_busy",   b_tr, cyc(1, 8));
        chk("E2_done",   d_tr, cyc(9, 9));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/morse_player.md
# morse_player

Serializes one letter (A–Z) into an on/off Morse keying signal, timed in units of an external tick enable. The design instantiates three copies, one per difficulty speed, each driven by a different tick rate. Their `signal` outputs feed the difficulty signal multiplexer as `signal1`/`signal2`/`signal3`. The element table is an internal ROM, and the block reports completion so the game controller can sequence letters.

## Interface
- `UNIT_TICKS`, default 4: tick pulses per Morse unit; legal range 1–255.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: single-cycle timing enable; may be tied high.
- `start` in 1: request to play `letter`; sampled only in IDLE.
- `letter` in 5: 0 = A … 25 = Z; values 26–31 are invalid.
- `signal` out 1: keying output; 1 = mark (LED/tone on).
- `busy` out 1: high from the cycle after an accepted `start` until playback ends.
- `done` out 1: one-cycle pulse in the first cycle back in IDLE.

## Operation
- **ROM entries:** each entry is {len[2:0] 1–4, pat[3:0]}.
  - The first element is `pat[len-1]`; later elements proceed toward bit 0.
  - 1 = dash, 0 = dot.
- **Codes:**
  - A .- ; B -... ; C -.-. ; D -.. ; E . ; F ..-. ; G --. ; H .... ; I .. ; J .---
  - K -.- ; L .-.. ; M -- ; N -. ; O --- ; P .--. ; Q --.- ; R .-. ; S ... ; T -
  - U ..- ; V ...- ; W .-- ; X -..- ; Y -.-- ; Z --..
- **States:** IDLE, MARK, GAP, LGAP.
- **IDLE:**
  - `signal`=0, `busy`=0.
  - `start`=1 with `letter`<26 → MARK. The letter's len/pat and the element index are latched.
  - `start` with `letter`≥26 is ignored: the block stays IDLE and `done` does not pulse.
- **MARK:** `signal`=1.
  - Target is UNIT_TICKS ticks for a dot, 3·UNIT_TICKS for a dash.
  - At target: go to GAP if elements remain, otherwise to LGAP.
- **GAP:** `signal`=0; target UNIT_TICKS; then MARK for the next element.
- **LGAP:** inter-letter gap, `signal`=0; target 3·UNIT_TICKS; then IDLE with `done`=1 for one cycle.
- **Tick counter:**
  - Clears to 0 on every state entry.
  - Increments on each cycle with `tick`=1.
  - The state transitions on the edge where `tick`=1 and count = target−1.
  - Counter width is 10 bits, enough for 3·255.
- `start` outside IDLE is ignored. A new letter may be started in the same cycle `done` is high, because the block is then in IDLE.
- `letter` is don't-care after acceptance; the latched copy is used.

## Timing
- **Reset values:**
  - State IDLE; `signal`=0, `busy`=0, `done`=0; counter 0.
  - Reset mid-playback takes effect at the next edge and wins over all other inputs.
- All outputs are registered; no combinational path from inputs to outputs.
- **Start latency:** `start` is sampled at edge N. `signal`=1 and `busy`=1 from cycle N+1.
- **Start and tick together:** if `tick` and `start` are both high at edge N, that tick does not count toward the first MARK.
- **Phase duration:** with `tick` high every cycle, each phase lasts exactly target cycles. In general a phase ends on the edge of its target-th tick.
- **Done timing:** `done` and `busy`=0 appear in the same cycle, directly after LGAP ends.
- `busy` stays 1 continuously through MARK, GAP and LGAP, with no glitches at phase boundaries.

## Test plan
- **E:** UNIT_TICKS=2, `tick`=1, start at edge 0.
  - `signal`=1 in cycles 1–2 and 0 in cycles 3–8.
  - `busy` is high in cycles 1–8; `done`=1 in cycle 9 only.
- **A:** UNIT_TICKS=2, `tick`=1.
  - `signal` is 1 for 2 cycles, 0 for 2, 1 for 6, then 0.
  - `busy` is high for 16 cycles; `done` in cycle 17.
- **Q with slow tick:** UNIT_TICKS=1, `tick` every 3rd cycle.
  - Mark lengths are 3, 3, 1, 3 ticks (9, 9, 3, 9 cycles ±phase); each gap is 1 tick.
  - LGAP is 3 ticks; `done` pulses once.
- **Invalid letter:** `letter`=26 with `start` → `busy` and `done` stay 0. Then `letter`=19 (T) → `signal` high for 3·UNIT_TICKS ticks.
- **Start while busy:** `start` with `letter`=H during T playback → ignored; the waveform is identical to T alone.
- **Reset mid-dash of O:** assert `reset` → next cycle `signal`=0, `busy`=0, `done`=0. A later start of E plays correctly from the first element.
